// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port
// (if_*) and the data-memory port (dm_*). Each access runs IDLE -> ISSUE ->
// WAIT (MEM_LATENCY cycles) -> DONE. The owner's ack pulses in DONE. DM wins
// ties unless IF has already lost MAX_IF_WAIT times in a row.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   if_req/if_addr    fetch request and address, held until if_ack
//   if_rdata/if_ack   fetched word (valid with ack), one-cycle completion
//   if_stall          if_req & ~if_ack
//   dm_req/dm_wr/dm_addr/dm_wdata
//                     data request (wr=1 store), held until dm_ack
//   dm_rdata/dm_ack   load data (valid with ack), one-cycle completion
//   dm_stall          dm_req & ~dm_ack
//   mem_en/mem_wr/mem_addr/mem_wdata
//                     memory strobe (ISSUE only) and latched command
//   mem_rdata         memory read data, valid MEM_LATENCY cycles after mem_en
//   busy              arbiter is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int MAX_IF_WAIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_stall,
   input  logic        dm_req,
   input  logic        dm_wr,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        dm_stall,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam int SW    = $clog2(MAX_IF_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(MEM_LATENCY - 1);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(MAX_IF_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             own_dm;
   logic [CNT_W-1:0] wait_cnt;
   logic [SW-1:0]    starve_cnt;
   logic             grant_dm;
   logic             grant_if;

   // Grant decision, only meaningful in IDLE. IF is forced through once it
   // has lost MAX_IF_WAIT consecutive ties.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      if (state == S_IDLE) begin
         if (dm_req && !(if_req && starve_cnt == STARVE_MAX))
            grant_dm = 1'b1;
         else if (if_req)
            grant_if = 1'b1;
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_dm || grant_if) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (wait_cnt == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      mem_en = (state == S_ISSUE);
      if_ack = (state == S_DONE) && !own_dm;
      dm_ack = (state == S_DONE) &&  own_dm;
      busy   = (state != S_IDLE);
   end

   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;

   // Owner, command latch, wait counter, starvation counter, read capture.
   // NOTE: the read-data registers are ordinary flops and are cleared on
   // reset so a port never sees stale data from an aborted access.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_dm     <= 1'b0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         if (grant_dm) begin
            own_dm    <= 1'b1;
            mem_wr    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Only a DM win over a waiting IF counts as starvation.
            if (if_req && starve_cnt != STARVE_MAX)
               starve_cnt <= starve_cnt + SW'(1);
         end else if (grant_if) begin
            own_dm     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
         end

         if (state == S_ISSUE)
            wait_cnt <= WAIT_LOAD;
         else if (state == S_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - CNT_W'(1);

         // Last WAIT cycle: memory data is valid now. Stores leave dm_rdata.
         if (state == S_WAIT && wait_cnt == '0) begin
            if (!own_dm)
               if_rdata <= mem_rdata;
            else if (!mem_wr)
               dm_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A transaction-level model predicts, per grant,
// the cycle of mem_en, of the ack and the data returned; a compare process
// checks every DUT output each cycle against it. A behavioural memory
// returns data only in the exact cycle it is valid. Directed scenarios add
// hand-computed latency and data expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MEM_LATENCY = 2;
   localparam int MAX_IF_WAIT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_stall;
   logic        dm_req = 1'b0;
   logic        dm_wr = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_stall;
   logic        mem_en;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   mem_port_arbiter #(
      .MEM_LATENCY(MEM_LATENCY),
      .MAX_IF_WAIT(MAX_IF_WAIT)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_stall(if_stall),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   // ---------------- behavioural memory ----------------
   logic [31:0] mem_arr [logic [31:0]];
   int          mem_valid_cyc = -100;
   logic [31:0] mem_pdata = '0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hA5A5_0F0F;
   endfunction

   // Read data appears only in the cycle MEM_LATENCY after the strobe.
   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_wr === 1'b1) begin
            mem_arr[mem_addr] = mem_wdata;
         end else begin
            mem_valid_cyc = cyc + MEM_LATENCY;
            mem_pdata     = mem_read(mem_addr);
         end
      end
      mem_rdata = (cyc == mem_valid_cyc) ? mem_pdata : (32'hBAD0_0000 ^ 32'(cyc));
   end

   // ---------------- transaction-level model ----------------
   bit          model_valid = 1'b0;
   int          m_grant_cyc = -100;
   int          m_en_cyc    = -100;
   int          m_ack_cyc   = -100;
   int          m_next_free = 0;
   bit          m_own_dm    = 1'b0;
   bit          m_store     = 1'b0;
   int          m_starve    = 0;
   logic [31:0] m_pdata     = '0;
   logic [31:0] m_if_rdata  = '0;
   logic [31:0] m_dm_rdata  = '0;
   logic [31:0] m_mem_addr  = '0;
   logic [31:0] m_mem_wdata = '0;
   logic        m_mem_wr    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         model_valid = 1'b1;
         m_grant_cyc = -100;
         m_en_cyc    = -100;
         m_ack_cyc   = -100;
         m_next_free = cyc + 1;
         m_starve    = 0;
         m_if_rdata  = '0;
         m_dm_rdata  = '0;
         m_mem_addr  = '0;
         m_mem_wdata = '0;
         m_mem_wr    = 1'b0;
      end else begin
         // Data captured at the edge closing the last wait cycle.
         if (cyc == m_ack_cyc - 1) begin
            if (!m_own_dm)     m_if_rdata = m_pdata;
            else if (!m_store) m_dm_rdata = m_pdata;
         end
         if (cyc >= m_next_free && (if_req || dm_req)) begin
            m_own_dm = dm_req && !(if_req && m_starve == MAX_IF_WAIT);
            if (m_own_dm) begin
               if (if_req && m_starve < MAX_IF_WAIT) m_starve++;
               m_store     = dm_wr;
               m_mem_addr  = dm_addr;
               m_mem_wr    = dm_wr;
               m_mem_wdata = dm_wdata;
            end else begin
               m_starve    = 0;
               m_store     = 1'b0;
               m_mem_addr  = if_addr;
               m_mem_wr    = 1'b0;
               m_mem_wdata = '0;
            end
            m_pdata     = mem_read(m_mem_addr);
            m_grant_cyc = cyc;
            m_en_cyc    = cyc + 1;
            m_ack_cyc   = cyc + 2 + MEM_LATENCY;
            m_next_free = cyc + 3 + MEM_LATENCY;
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      logic e_en, e_if_ack, e_dm_ack, e_busy;
      #2;
      if (model_valid) begin
         e_en     = (cyc == m_en_cyc);
         e_if_ack = (cyc == m_ack_cyc) && !m_own_dm;
         e_dm_ack = (cyc == m_ack_cyc) &&  m_own_dm;
         e_busy   = (cyc > m_grant_cyc) && (cyc <= m_ack_cyc);
         check1("mem_en",   mem_en,   e_en);
         check1("mem_wr",   mem_wr,   m_mem_wr);
         check ("mem_addr", mem_addr, m_mem_addr);
         if (e_en && m_mem_wr) check("mem_wdata", mem_wdata, m_mem_wdata);
         check1("if_ack",   if_ack,   e_if_ack);
         check1("dm_ack",   dm_ack,   e_dm_ack);
         check ("if_rdata", if_rdata, m_if_rdata);
         check ("dm_rdata", dm_rdata, m_dm_rdata);
         check1("busy",     busy,     e_busy);
         check1("if_stall", if_stall, if_req && !e_if_ack);
         check1("dm_stall", dm_stall, dm_req && !e_dm_ack);
      end
   end

   // Runs one transaction from the current negedge until its ack (bounded).
   task automatic run_txn(input bit is_dm, output int en_lat, output int ack_lat,
                          output logic [31:0] en_addr, output logic en_wr,
                          output logic [31:0] en_wdata);
      en_lat = -1; ack_lat = -1; en_addr = '0; en_wr = 1'b0; en_wdata = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_en && en_lat < 0) begin
            en_lat = n; en_addr = mem_addr; en_wr = mem_wr; en_wdata = mem_wdata;
         end
         if (is_dm ? dm_ack : if_ack) begin
            ack_lat = n;
            break;
         end
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int          en_lat, ack_lat, dm_lat, if_lat, en_cnt, ack_cnt, dm_done;
      logic [31:0] en_addr, en_wdata;
      logic        en_wr;
      int          seq[$];
      int          exp_seq[6] = '{1, 1, 1, 0, 1, 1};

      mem_arr[32'h0000_0010] = 32'h2008_0005;
      mem_arr[32'h0000_0020] = 32'hCAFE_0001;
      mem_arr[32'h0000_0044] = 32'h1234_5678;

      // Reset state.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check1("rst_busy",     busy,     1'b0);
      check1("rst_mem_en",   mem_en,   1'b0);
      check ("rst_mem_addr", mem_addr, 32'h0);
      check ("rst_mem_wdata",mem_wdata,32'h0);
      check ("rst_if_rdata", if_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // IF-only fetch.
      if_addr = 32'h0000_0010; if_req = 1'b1;
      #1 check1("fetch_stall_T", if_stall, 1'b1);
      run_txn(1'b0, en_lat, ack_lat, en_addr, en_wr, en_wdata);
      if_req = 1'b0;
      check("fetch_en_lat",  en_lat,   1);
      check("fetch_en_addr", en_addr,  32'h0000_0010);
      check("fetch_ack_lat", ack_lat,  4);
      check("fetch_rdata",   if_rdata, 32'h2008_0005);
      @(negedge clk);

      // DM store.
      dm_wr = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
      run_txn(1'b1, en_lat, ack_lat, en_addr, en_wr, en_wdata);
      dm_req = 1'b0; dm_wr = 1'b0;
      check1("store_mem_wr",   en_wr,    1'b1);
      check ("store_addr",     en_addr,  32'h40);
      check ("store_wdata",    en_wdata, 32'hDEAD_BEEF);
      check ("store_ack_lat",  ack_lat,  4);
      check ("store_dm_rdata", dm_rdata, 32'h0);
      @(negedge clk);

      // Simultaneous requests: DM first, IF next.
      dm_lat = -1; if_lat = -1;
      if_addr = 32'h20; dm_addr = 32'h44; if_req = 1'b1; dm_req = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (dm_ack) begin dm_lat = n; dm_req = 1'b0; end
         if (if_ack) begin if_lat = n; if_req = 1'b0; break; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      check("both_dm_lat",   dm_lat,   4);
      check("both_if_lat",   if_lat,   9);
      check("both_dm_rdata", dm_rdata, 32'h1234_5678);
      check("both_if_rdata", if_rdata, 32'hCAFE_0001);
      @(negedge clk);

      // Starvation: IF waits behind back-to-back DM loads.
      dm_done = 0;
      if_addr = 32'h30; dm_addr = 32'h100; if_req = 1'b1; dm_req = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (dm_ack) begin
            seq.push_back(1);
            dm_done++;
            if (dm_done == 5) dm_req = 1'b0;
            else dm_addr = dm_addr + 32'd4;
         end
         if (if_ack) begin seq.push_back(0); if_req = 1'b0; end
         if (dm_done == 5 && !if_req) break;
      end
      if_req = 1'b0; dm_req = 1'b0;
      check("starve_count", seq.size(), 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("starve_order%0d", i), (i < seq.size()) ? seq[i] : 9, exp_seq[i]);
      @(negedge clk);

      // Flush: IF request dropped during WAIT.
      en_cnt = 0; ack_cnt = 0;
      if_addr = 32'h50; if_req = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (if_ack) ack_cnt++;
         if (n == 2) if_req = 1'b0;
      end
      check("flush_mem_en_count", en_cnt,  1);
      check("flush_ack_count",    ack_cnt, 1);

      // Reset during WAIT.
      dm_wr = 1'b0; dm_addr = 32'h60; dm_req = 1'b1;
      repeat (2) @(negedge clk);
      check1("rw_busy_before", busy, 1'b1);
      rst = 1'b1; dm_req = 1'b0;
      @(negedge clk);
      check1("rw_busy",     busy,     1'b0);
      check1("rw_dm_ack",   dm_ack,   1'b0);
      check1("rw_mem_en",   mem_en,   1'b0);
      check ("rw_if_rdata", if_rdata, 32'h0);
      check ("rw_dm_rdata", dm_rdata, 32'h0);
      rst = 1'b0;
      ack_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (dm_ack) ack_cnt++;
      end
      check("rw_no_late_ack", ack_cnt, 0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-port unified memory between the pipeline's instruction-fetch port (IF) and its data-memory port (MEM-stage loads/stores).
It sequences each access as issue, fixed-latency wait, then acknowledge, and drives per-port stall signals that freeze the requesting pipeline stages until the access is acknowledged.
It sits between the pipelined core's inst/data interfaces and the memory model.

Parameters:
MEM_LATENCY, 2, cycles from mem_en cycle to mem_rdata valid (>=1)
MAX_IF_WAIT, 3, consecutive DM wins tolerated while IF waits before IF is forced to win (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held with if_addr until if_ack
if_addr  input  32  fetch address
if_rdata  output  32  fetched instruction, valid while if_ack=1
if_ack  output  1  one-cycle fetch completion pulse
if_stall  output  1  if_req & ~if_ack (combinational)
dm_req  input  1  data request, held with dm_wr/addr/wdata until dm_ack
dm_wr  input  1  1=store, 0=load
dm_addr  input  32  data address
dm_wdata  input  32  store data
dm_rdata  output  32  load data, valid while dm_ack=1
dm_ack  output  1  one-cycle data completion pulse
dm_stall  output  1  dm_req & ~dm_ack (combinational)
mem_en  output  1  memory access strobe, one cycle per access
mem_wr  output  1  memory write enable, qualified by mem_en
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after mem_en cycle
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Owner register own_dm records the granted port.
- IDLE, neither req: stay.
- IDLE, one req: grant it; latch addr, wr (0 for IF), wdata into mem_* registers; go to ISSUE.
- IDLE, both req: DM wins unless starve_cnt==MAX_IF_WAIT, in which case IF wins.
- starve_cnt: +1 (saturating at MAX_IF_WAIT) on each DM grant while if_req=1; cleared on every IF grant.
- ISSUE, one cycle: mem_en=1, mem_wr=latched wr; load WAIT counter with MEM_LATENCY-1; go to WAIT.
- WAIT, MEM_LATENCY cycles: mem_en=0; count down.
  - At cnt==0, register mem_rdata into the owner's rdata register. Stores do not update dm_rdata.
  - Go to DONE.
- DONE, one cycle: owner's ack=1; go to IDLE. The acked port's request is not re-evaluated until IDLE.
- Latency: req seen in IDLE at cycle T gives mem_en at T+1, rdata sampled at T+1+MEM_LATENCY, ack at T+2+MEM_LATENCY.
- Minimum spacing between grants is MEM_LATENCY+3 cycles.
- mem_addr, mem_wr and mem_wdata hold their latched values from ISSUE until the next grant.
- if_rdata and dm_rdata hold their last captured values between acks.
- A request dropped mid-transaction (e.g. pipeline flush) does not abort the access. The ack still pulses and rdata still updates; the requester ignores it.
- Inputs changing during ISSUE, WAIT or DONE have no effect on the in-flight access.
- Reset, including mid-operation:
  - state=IDLE, own_dm=0, starve_cnt=0, WAIT counter=0.
  - mem_en=0, mem_wr=0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - if_ack=0, dm_ack=0. if_stall and dm_stall follow the req inputs.
- At most one ack per cycle. mem_en is never asserted outside ISSUE.

Test Plan:
- Reset, then IF-only fetch: if_req=1, if_addr=0x0000_0010, memory returns 0x2008_0005 → mem_en pulse at T+1 with mem_addr=0x10; if_ack and if_rdata=0x2008_0005 at T+4 (MEM_LATENCY=2); if_stall=1 from T to T+3.
- DM store: dm_req=1, dm_wr=1, dm_addr=0x40, dm_wdata=0xDEAD_BEEF → single mem_en with mem_wr=1, mem_addr=0x40, mem_wdata=0xDEAD_BEEF; dm_ack at T+4; dm_rdata unchanged.
- Simultaneous if_req and dm_req (load of 0x44) → DM granted first; dm_ack at T+4; IF granted in the next IDLE; if_ack at T+9.
- Starvation: IF held high while DM issues 5 back-to-back loads → DM wins 3 grants, the 4th grant goes to IF, starve_cnt returns to 0, then DM resumes.
- Flush: drop if_req during WAIT → access completes; if_ack still pulses once; no second mem_en issued for IF.
- Reset asserted during WAIT → next cycle: busy=0, acks=0, mem_en=0, rdata registers=0; no ack ever appears for the aborted access.
